// File: rtl/dsram_resp_pkg.sv
// Shared definitions for the data-SRAM responder and its requester (EX stage).
//   dsram_st_e   : responder FSM states (IDLE accepts, WAIT holds a pending read)
//   DSRAM_LANE_W : byte-lane width
//   DSRAM_REQ_W  : width of the data_sram request bundle {en, wen, addr, wdata}
package dsram_resp_pkg;

  typedef enum logic [0:0] {
    DSRAM_ST_IDLE = 1'b0,
    DSRAM_ST_WAIT = 1'b1
  } dsram_st_e;

  localparam int unsigned DSRAM_LANE_W = 8;
  localparam int unsigned DSRAM_LANES  = 4;
  localparam int unsigned DSRAM_WORD_W = DSRAM_LANE_W * DSRAM_LANES;
  localparam int unsigned DSRAM_REQ_W  = 1 + DSRAM_LANES + 32 + DSRAM_WORD_W; // 69

  typedef struct packed {
    logic                    en;
    logic [DSRAM_LANES-1:0]  wen;
    logic [31:0]             addr;
    logic [DSRAM_WORD_W-1:0] wdata;
  } dsram_req_t;

endpackage

// File: rtl/dsram_bank.sv
// Pure storage array: 2**AW words of 32 bits, per-byte-lane write enables and
// a registered read port. The read register only updates when re is high, so
// it holds the last read word. Nothing here is reset.
//   clk   : clock
//   we    : per-lane write enables, write commits on the rising edge
//   waddr : write word address
//   wdata : write data, lane-aligned
//   re    : read enable
//   raddr : read word address
//   rdata : registered read data
module dsram_bank
  import dsram_resp_pkg::*;
#(
  parameter int unsigned AW = 12
) (
  input  logic                    clk,
  input  logic [DSRAM_LANES-1:0]  we,
  input  logic [AW-1:0]           waddr,
  input  logic [DSRAM_WORD_W-1:0] wdata,
  input  logic                    re,
  input  logic [AW-1:0]           raddr,
  output logic [DSRAM_WORD_W-1:0] rdata
);

  logic [DSRAM_WORD_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DSRAM_LANES; i++) begin
      if (we[i]) begin
        mem[waddr][i*DSRAM_LANE_W +: DSRAM_LANE_W] <= wdata[i*DSRAM_LANE_W +: DSRAM_LANE_W];
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dsram_resp.sv
// Data-SRAM responder: memory side of the data_sram_* interface.
//   clk             : core clock
//   resetn          : asynchronous active-low reset
//   data_sram_en    : request valid
//   data_sram_wen   : byte-lane write enables, 0 with en=1 is a read
//   data_sram_addr  : byte address, bits [AW+1:2] select the word
//   data_sram_wdata : lane-aligned write data
//   data_sram_rdata : last completed read word (0 after reset)
//   rdata_valid     : one-cycle pulse when data_sram_rdata shows a new result
//   stallreq        : high while a read is outstanding (LATENCY>1 only)
module dsram_resp
  import dsram_resp_pkg::*;
#(
  parameter int unsigned AW      = 12,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned CW      = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        rdata_valid,
  output logic        stallreq
);

  dsram_st_e               state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [AW-1:0]           lat_q, lat_d;
  logic [AW-1:0]           req_word, rd_word;
  logic [DSRAM_LANES-1:0]  bank_we;
  logic                    rd_fire;
  logic                    rd_seen_q;
  logic                    valid_q;
  logic [DSRAM_WORD_W-1:0] bank_q;
  logic                    unused_addr_bits;

  assign req_word         = data_sram_addr[AW+1:2];
  assign unused_addr_bits = ^{data_sram_addr[31:AW+2], data_sram_addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    rd_fire = 1'b0;
    rd_word = req_word;
    bank_we = '0;
    case (state_q)
      DSRAM_ST_IDLE: begin
        if (data_sram_en) begin
          if (|data_sram_wen) begin
            bank_we = data_sram_wen;
          end else if (LATENCY == 1) begin
            rd_fire = 1'b1;
          end else begin
            state_d = DSRAM_ST_WAIT;
            cnt_d   = CW'(LATENCY - 1);
            lat_d   = req_word;
          end
        end
      end
      DSRAM_ST_WAIT: begin
        rd_word = lat_q;
        if (cnt_q == CW'(1)) begin
          rd_fire = 1'b1;
          cnt_d   = '0;
          state_d = DSRAM_ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = DSRAM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= DSRAM_ST_IDLE;
      cnt_q     <= '0;
      lat_q     <= '0;
      rd_seen_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      rd_seen_q <= rd_seen_q | rd_fire;
      valid_q   <= rd_fire;
    end
  end

  dsram_bank #(
    .AW(AW)
  ) u_bank (
    .clk  (clk),
    .we   (bank_we),
    .waddr(req_word),
    .wdata(data_sram_wdata),
    .re   (rd_fire),
    .raddr(rd_word),
    .rdata(bank_q)
  );

  // The bank's read register has no reset; rd_seen_q masks it to zero until
  // the first read after reset, giving the reset value of data_sram_rdata.
  assign data_sram_rdata = rd_seen_q ? bank_q : '0;
  assign rdata_valid     = valid_q;
  assign stallreq        = (state_q == DSRAM_ST_WAIT);

endmodule
